alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered ALU stage directly downstream of the datapath shifter.
- Consumes operand A (from register A) and shifted operand B (the shifter output), performs one of four 2-bit-encoded ALU ops, and buffers result plus status flags in a small FIFO.
- Uses a valid/ready handshake on both sides so the writeback/status logic can stall the datapath.

Parameters:
- WIDTH, 16, datapath word width in bits.
- DEPTH, 2, output buffer entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set on ain/bin/aluop is valid
- in_ready  output  1  stage can accept an operand set this cycle
- ain  input  WIDTH  operand A
- bin  input  WIDTH  operand B (shifter output)
- aluop  input  2  00 ADD, 01 SUB, 10 AND, 11 MVN
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer takes head entry this cycle
- out_c  output  WIDTH  head result
- out_status  output  3  head flags {V,N,Z}, Z in bit 0
- occupancy  output  $clog2(DEPTH)+1  current entry count

Behaviour:
- Reset (async, any time, including mid-stream):
  - Buffer emptied; read and write pointers = 0; occupancy = 0.
  - out_valid = 0; out_c = 0; out_status = 0; in_ready = 1 once reset deasserts.
  - Entries in flight are discarded.
- Handshake:
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - in_ready = (occupancy < DEPTH), purely from registered state; no combinational path from out_ready.
  - out_valid = (occupancy != 0).
  - out_c and out_status are driven from the head entry and held stable while out_valid && !out_ready.
- Latency: an operand set accepted at edge N appears at the head at edge N+1 when the buffer was empty. Otherwise it queues in FIFO order.
- Arithmetic (result truncated to WIDTH, carry discarded):
  - ADD: res = ain + bin.
  - SUB: res = ain - bin.
  - AND: res = ain & bin.
  - MVN: res = ~bin (ain ignored).
- Flags, computed at push:
  - Z = (res == 0).
  - N = res[WIDTH-1].
  - ADD: V = (ain[msb]==bin[msb]) && (res[msb]!=ain[msb]).
  - SUB: V = (ain[msb]!=bin[msb]) && (res[msb]!=ain[msb]).
  - AND/MVN: V = 0.
- Simultaneous push and pop:
  - Allowed whenever in_ready=1; occupancy unchanged; pointers both advance.
  - When full, in_ready=0, so only the pop occurs that cycle; push is possible the following cycle.
- Empty: a pop request with out_valid=0 is ignored; pointers and occupancy unchanged.
- Pointers wrap modulo DEPTH.
- in_valid while in_ready=0: no state change; upstream must hold its operands.

Optional Feature:
- Macro: ALU_SATURATE_EN.
- Defined: when ADD/SUB overflows (V=1), res is clamped:
  - 2^(WIDTH-1)-1 if ain[msb]=0;
  - -2^(WIDTH-1) if ain[msb]=1.
  - V stays 1; Z and N are computed on the clamped value.
- Not defined: wrap-around two's-complement result as above. No saturation logic is synthesized.

Test Plan:
- Reset mid-stream: push 2 entries, assert reset for 1 cycle -> out_valid=0, occupancy=0, out_c=0, out_status=0 immediately (async); in_ready=1 after release.
- ADD overflow: ain=16'h7FFF, bin=16'h0001, aluop=00, out_ready=1 -> next cycle out_c=16'h8000, status V=1,N=1,Z=0. With ALU_SATURATE_EN: out_c=16'h7FFF, V=1,N=0,Z=0.
- SUB to zero: ain=16'h0005, bin=16'h0005, aluop=01 -> out_c=16'h0000, Z=1,N=0,V=0.
- MVN and AND:
  - bin=16'h00FF, aluop=11 -> out_c=16'hFF00, N=1.
  - ain=16'hF0F0, bin=16'h0FF0, aluop=10 -> out_c=16'h00F0, flags 0.
- Backpressure/full: out_ready=0, push 3 sets (1,2,3 via ADD with bin=0).
  - -> in_ready=0 after 2nd push; 3rd held.
  - -> out_c stays 1 while stalled.
  - Raise out_ready -> outputs 1,2,3 in order; occupancy never exceeds 2.
- Simultaneous push/pop: occupancy=1, in_valid=1 and out_ready=1 in same cycle -> occupancy stays 1, head advances to new entry, no data lost or duplicated.

Source files
------------

// File: rtl/alu_result_stage.sv
// Registered ALU stage with a small result/flag FIFO and valid/ready on both sides.
// Define ALU_SATURATE_EN to clamp signed ADD/SUB overflow instead of wrapping.
module alu_result_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           ain,
  input  logic [WIDTH-1:0]           bin,
  input  logic [1:0]                 aluop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_c,
  output logic [2:0]                 out_status,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   OCC_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   OCC_DEPTH = (AW + 1)'(DEPTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  logic [WIDTH-1:0] mem_c [DEPTH];
  logic [2:0]       mem_s [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] res;
  logic             flag_v;
  logic             flag_n;
  logic             flag_z;

  // Handshake derives only from registered count, so out_ready never reaches in_ready.
  assign in_ready  = (count < OCC_DEPTH);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occupancy = count;

  // Head is masked while empty so outputs read zero after reset without clearing storage.
  assign out_c      = out_valid ? mem_c[rd_ptr] : '0;
  assign out_status = out_valid ? mem_s[rd_ptr] : '0;

  always_comb begin
    res    = '0;
    flag_v = 1'b0;
    case (aluop)
      OP_ADD: begin
        res    = ain + bin;
        flag_v = (ain[WIDTH-1] == bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_SUB: begin
        res    = ain - bin;
        flag_v = (ain[WIDTH-1] != bin[WIDTH-1]) && (res[WIDTH-1] != ain[WIDTH-1]);
      end
      OP_AND: res = ain & bin;
      OP_MVN: res = ~bin;
      default: res = '0;
    endcase
`ifdef ALU_SATURATE_EN
    if (flag_v) begin
      res = ain[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    flag_n = res[WIDTH-1];
    flag_z = (res == '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_c[wr_ptr] <= res;
      mem_s[wr_ptr] <= {flag_v, flag_n, flag_z};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + OCC_ONE;
        2'b01:   count <= count - OCC_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized plus directed bench for alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;

  localparam int W = 16;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] ain;
  logic [W-1:0] bin;
  logic [1:0]   aluop;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_c;
  logic [2:0]   out_status;
  logic [$clog2(D):0] occupancy;

  int total = 0;
  int bad   = 0;
  logic [18:0] model_q[$];

  alu_result_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .ain(ain), .bin(bin), .aluop(aluop),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_status(out_status), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {V,N,Z,result}; signed overflow judged on the exact integer result.
  function automatic logic [18:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op);
    int sa, sb, full;
    logic [W-1:0] r;
    logic v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    v = 1'b0;
    r = '0;
    case (op)
      2'd0, 2'd1: begin
        full = (op == 2'd0) ? sa + sb : sa - sb;
        v = (full > 32767) || (full < -32768);
        r = full[W-1:0];
`ifdef ALU_SATURATE_EN
        if (v) r = (full > 0) ? 16'h7FFF : 16'h8000;
`endif
      end
      2'd2: r = a & b;
      default: r = ~b;
    endcase
    return {v, r[W-1], (r == 0), r};
  endfunction

  task automatic check_model();
    int n;
    n = model_q.size();
    check_val("out_valid", 32'(out_valid), 32'(n != 0));
    check_val("in_ready", 32'(in_ready), 32'(n < D));
    check_val("occupancy", 32'(occupancy), 32'(n));
    if (n != 0) begin
      check_val("out_c", 32'(out_c), 32'(model_q[0][15:0]));
      check_val("out_status", 32'(out_status), 32'(model_q[0][18:16]));
    end else begin
      check_val("out_c_empty", 32'(out_c), 32'h0);
      check_val("out_status_empty", 32'(out_status), 32'h0);
    end
  endtask

  task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic ordy);
    logic do_push, do_pop;
    @(negedge clk);
    check_model();
    in_valid  = iv;
    ain       = a;
    bin       = b;
    aluop     = op;
    out_ready = ordy;
    do_push = iv && (model_q.size() < D);
    do_pop  = (model_q.size() > 0) && ordy;
    @(posedge clk);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(ref_op(a, b, op));
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_val("rst_out_valid", 32'(out_valid), 32'h0);
    check_val("rst_occupancy", 32'(occupancy), 32'h0);
    check_val("rst_out_c", 32'(out_c), 32'h0);
    check_val("rst_out_status", 32'(out_status), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();
    #1;
    check_val("rst_in_ready", 32'(in_ready), 32'h1);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(7))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ain = '0; bin = '0; aluop = 2'b00;
    #12;
    @(negedge clk);
    reset = 1'b0;

    // Reset landing on a partially filled buffer.
    cycle(1, 16'h0011, 16'h0001, 2'b00, 0);
    cycle(1, 16'h0022, 16'h0001, 2'b00, 0);
    apply_reset();

    cycle(1, 16'h7FFF, 16'h0001, 2'b00, 1);
`ifdef ALU_SATURATE_EN
    check_val("add_ovf_c", 32'(out_c), 32'h7FFF);
    check_val("add_ovf_s", 32'(out_status), 32'b100);
`else
    check_val("add_ovf_c", 32'(out_c), 32'h8000);
    check_val("add_ovf_s", 32'(out_status), 32'b110);
`endif
    cycle(1, 16'h0005, 16'h0005, 2'b01, 1);
    check_val("sub_zero_c", 32'(out_c), 32'h0000);
    check_val("sub_zero_s", 32'(out_status), 32'b001);
    check_val("pushpop_occ", 32'(occupancy), 32'h1);
    cycle(1, 16'h1234, 16'h00FF, 2'b11, 1);
    check_val("mvn_c", 32'(out_c), 32'hFF00);
    check_val("mvn_s", 32'(out_status), 32'b010);
    cycle(1, 16'hF0F0, 16'h0FF0, 2'b10, 1);
    check_val("and_c", 32'(out_c), 32'h00F0);
    check_val("and_s", 32'(out_status), 32'b000);
    cycle(0, 16'h0, 16'h0, 2'b00, 1);

    // Fill under backpressure, then drain in order.
    cycle(1, 16'h0001, 16'h0000, 2'b00, 0);
    cycle(1, 16'h0002, 16'h0000, 2'b00, 0);
    check_val("full_in_ready", 32'(in_ready), 32'h0);
    check_val("full_occ", 32'(occupancy), 32'h2);
    cycle(1, 16'h0003, 16'h0000, 2'b00, 0);
    check_val("stall_c", 32'(out_c), 32'h1);
    cycle(1, 16'h0003, 16'h0000, 2'b00, 1);
    check_val("drain_c2", 32'(out_c), 32'h2);
    cycle(1, 16'h0003, 16'h0000, 2'b00, 1);
    check_val("drain_c3", 32'(out_c), 32'h3);
    check_val("drain_occ", 32'(occupancy), 32'h1);
    cycle(0, 16'h0, 16'h0, 2'b00, 1);

    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 999) apply_reset();
      cycle(($urandom_range(3) != 0), pick_operand(), pick_operand(),
            2'($urandom_range(3)), ($urandom_range(2) != 0));
    end
    @(negedge clk);
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
